mux_scan_collector: RTL and testbench
=====================================

Name: mux_scan_collector

Overview:
- Downstream companion to the 8:1 one-bit select mux.
- Drives the mux select through channels 0..7 and samples the mux output once per channel.
- Assembles the eight samples into one 8-bit word and offers it on a valid/ready output.
- Lets the next stage read a snapshot of all eight inputs through the single mux output bit.

Parameters:
- N_CH, 8, number of mux channels scanned; fixed at 8 for this revision.
- SEL_W, 3, select width, log2(N_CH).

Ports:
- clock  input  1  single clock; all flops rising-edge.
- reset  input  1  asynchronous, active-high reset.
- io_start  input  1  request one scan; sampled only in IDLE.
- io_cont  input  1  continuous mode; when 1, a new scan starts automatically after each output handshake.
- io_sel  output  SEL_W  registered select driven to the mux.
- io_bit  input  1  mux output for the currently driven io_sel.
- io_busy  output  1  high in SCAN or HOLD.
- io_out_valid  output  1  word available.
- io_out_ready  input  1  consumer accepts the word.
- io_out_bits  output  N_CH  assembled word; bit i = value of mux input i.

Behaviour:
- Reset (async assert, sync deassert at the top level):
  - state=IDLE, io_sel=0, io_out_bits=0, io_out_valid=0, io_busy=0.
  - Reset mid-scan or mid-hold discards the partial or pending word immediately.
- FSM states: IDLE, SCAN, HOLD.
- IDLE:
  - io_sel held at 0.
  - When io_start=1 or io_cont=1: next state SCAN; io_sel stays 0.
- SCAN:
  - The mux is combinational, so io_bit reflects the current io_sel in the same cycle.
  - Each SCAN cycle: io_out_bits[io_sel] <= io_bit.
  - If io_sel<7: io_sel <= io_sel+1.
  - If io_sel==7: io_sel <= 0, state <= HOLD, io_out_valid <= 1.
  - Exactly 8 SCAN cycles per word, no gaps.
- Latency: start accepted at edge 0 → samples taken at edges 1..8 → io_out_valid high from edge 8 onward.
  - Equivalently, the first cycle io_out_valid=1 is 9 cycles after io_start is presented.
- HOLD:
  - io_out_valid=1; io_out_bits stable and unchanged until handshake.
  - Handshake = io_out_valid & io_out_ready at a rising edge.
  - On handshake: io_out_valid <= 0; if io_cont=1 then SCAN with io_sel=0, else IDLE.
  - io_out_valid never depends combinationally on io_out_ready.
- io_out_bits:
  - Bits not yet rewritten in the current scan hold values from the previous word.
  - Consumers read only while io_out_valid=1.
- io_busy = (state != IDLE); registered-state decode, no combinational path from inputs.
- Simultaneous events:
  - io_start during SCAN or HOLD is ignored; it is not queued.
  - io_cont sampled at handshake time only (and in IDLE).
  - io_cont falling mid-scan finishes the current word, then returns to IDLE.
- io_sel only ever takes values 0..7; wrap 7→0 happens only at scan end.
- Throughput in continuous mode with io_out_ready tied high: one word per 9 cycles (8 SCAN + 1 HOLD).

Decomposition:
- Shared package:
  - state enum {IDLE, SCAN, HOLD} (2-bit encoding).
  - N_CH and SEL_W constants, also used by the mux wrapper.
  - LAST_SEL = N_CH-1.
- No sub-module required.
- Optional: a tiny sel_counter (SEL_W-bit up-counter with load-zero and terminal-count flag), shared with other scan blocks.

Test Plan:
- Mux inputs = 8'b1010_0110 (in0=0, in1=1, ...), io_start pulse one cycle, io_out_ready=1 → io_sel steps 0..7 over 8 cycles; io_out_valid high exactly 1 cycle; io_out_bits=8'hA6; then IDLE, io_busy=0.
- Inputs = 8'h5C, io_out_ready=0 for 20 cycles after valid → io_out_valid and io_out_bits=8'h5C stable throughout; io_start pulses during HOLD ignored; one handshake when ready rises, then IDLE.
- io_cont=1, io_out_ready=1, inputs change 8'h01→8'hFF between scans → back-to-back words 8'h01 then 8'hFF; valid pulses every 9 cycles; io_sel wraps 7→0 with no idle cycle.
- Assert reset while io_sel=4 in SCAN → io_sel=0, io_out_valid=0, io_out_bits=0, io_busy=0 immediately (asynchronous); next io_start produces a full correct word.
- io_cont dropped at io_sel=3 with inputs 8'h3C → current word completes as 8'h3C; after handshake state returns to IDLE and no further scan starts.
- io_start and io_cont both 0 for 50 cycles after reset → io_sel=0, io_busy=0, io_out_valid=0 throughout.

Source files
------------

// File: rtl/mux_scan_collector_pkg.sv
// Shared constants and state encoding for the mux scan collector.
// Also used by the 8:1 mux wrapper for channel count and select width.
package mux_scan_collector_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = $clog2(N_CH);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_collector_if.sv
// Handshake/bus bundle between the scan collector and its mux/consumer.
// master: collector side; slave: mux, control and consumer side.
interface mux_scan_collector_if;
    import mux_scan_collector_pkg::*;

    logic             io_start;
    logic             io_cont;
    logic [SEL_W-1:0] io_sel;
    logic             io_bit;
    logic             io_busy;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [N_CH-1:0]  io_out_bits;

    modport master (
        input  io_start,
        input  io_cont,
        input  io_bit,
        input  io_out_ready,
        output io_sel,
        output io_busy,
        output io_out_valid,
        output io_out_bits
    );

    modport slave (
        output io_start,
        output io_cont,
        output io_bit,
        output io_out_ready,
        input  io_sel,
        input  io_busy,
        input  io_out_valid,
        input  io_out_bits
    );

endinterface

// File: rtl/mux_scan_collector.sv
// Steps the mux select through all channels, collects one bit per channel
// and offers the assembled word on a valid/ready output.
// Ports: clock, reset (async active-high), io (master modport: start/cont
// control, sel/bit mux link, busy, out_valid/out_ready/out_bits).
module mux_scan_collector
    import mux_scan_collector_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    mux_scan_collector_if.master  io
);

    // Reset asserts immediately, releases two clock edges later so that
    // the FSM never leaves reset on an edge that races the deassertion.
    logic rst_meta;
    logic rst_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_meta <= 1'b1;
            rst_sync <= 1'b1;
        end else begin
            rst_meta <= 1'b0;
            rst_sync <= rst_meta;
        end
    end

    state_t           state;
    logic [SEL_W-1:0] sel;
    logic [N_CH-1:0]  bits;
    logic             valid;

    always_ff @(posedge clock or posedge rst_sync) begin
        if (rst_sync) begin
            state <= IDLE;
            sel   <= '0;
            bits  <= '0;
            valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    sel <= '0;
                    if (io.io_start || io.io_cont) begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    // Mux is combinational: io_bit already reflects sel.
                    bits[sel] <= io.io_bit;
                    if (sel == LAST_SEL) begin
                        sel   <= '0;
                        state <= HOLD;
                        valid <= 1'b1;
                    end else begin
                        sel <= sel + 1'b1;
                    end
                end
                HOLD: begin
                    if (io.io_out_ready) begin
                        valid <= 1'b0;
                        state <= io.io_cont ? SCAN : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    sel   <= '0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign io.io_sel       = sel;
    assign io.io_out_bits  = bits;
    assign io.io_out_valid = valid;
    assign io.io_busy      = (state != IDLE);

endmodule

// File: tb/tb_mux_scan_collector.sv
// Directed bench for mux_scan_collector with a behavioural 8:1 mux.
// Expected words and select sequences are hand-computed constants.
module tb_mux_scan_collector;

    logic       clock;
    logic       reset;
    logic [7:0] mux_in;

    int checks;
    int errors;

    mux_scan_collector_if io ();

    mux_scan_collector dut (
        .clock (clock),
        .reset (reset),
        .io    (io.master)
    );

    assign io.io_bit = mux_in[io.io_sel];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Caller raises io_start or io_cont at a negedge, then calls this.
    // Checks the select stepping 0..7 and the word appearing on valid.
    task automatic run_scan(input logic [7:0] exp, input int drop_at);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            io.io_start = 1'b0;
            check("scan_sel", 32'(io.io_sel), i);
            check("scan_valid", 32'(io.io_out_valid), 0);
            check("scan_busy", 32'(io.io_busy), 1);
            if (i == drop_at) io.io_cont = 1'b0;
        end
        @(negedge clock);
        check("word_valid", 32'(io.io_out_valid), 1);
        check("word_bits", 32'(io.io_out_bits), 32'(exp));
        check("word_sel", 32'(io.io_sel), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        mux_in       = 8'h00;
        io.io_start     = 1'b0;
        io.io_cont      = 1'b0;
        io.io_out_ready = 1'b0;
        #1;
        check("rst_sel", 32'(io.io_sel), 0);
        check("rst_valid", 32'(io.io_out_valid), 0);
        check("rst_bits", 32'(io.io_out_bits), 0);
        check("rst_busy", 32'(io.io_busy), 0);
        do_reset();

        // Idle for 50 cycles: nothing moves.
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            check("idle_sel", 32'(io.io_sel), 0);
            check("idle_busy", 32'(io.io_busy), 0);
            check("idle_valid", 32'(io.io_out_valid), 0);
        end

        // Single scan, consumer always ready.
        mux_in = 8'hA6;
        io.io_out_ready = 1'b1;
        io.io_start = 1'b1;
        run_scan(8'hA6, -1);
        @(negedge clock);
        check("t1_valid_off", 32'(io.io_out_valid), 0);
        check("t1_busy_off", 32'(io.io_busy), 0);
        check("t1_bits_keep", 32'(io.io_out_bits), 32'h A6);

        // Backpressure: word held for 20 cycles, start ignored.
        mux_in = 8'h5C;
        io.io_out_ready = 1'b0;
        io.io_start = 1'b1;
        run_scan(8'h5C, -1);
        mux_in = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            io.io_start = (i % 4 == 1);
            @(negedge clock);
            check("t2_hold_valid", 32'(io.io_out_valid), 1);
            check("t2_hold_bits", 32'(io.io_out_bits), 32'h5C);
            check("t2_hold_sel", 32'(io.io_sel), 0);
        end
        io.io_start = 1'b0;
        io.io_out_ready = 1'b1;
        @(negedge clock);
        check("t2_hs_valid", 32'(io.io_out_valid), 0);
        check("t2_hs_busy", 32'(io.io_busy), 0);
        repeat (5) @(negedge clock);
        check("t2_no_queue", 32'(io.io_busy), 0);

        // Continuous mode: back-to-back words, 9 cycles each.
        mux_in = 8'h01;
        io.io_cont = 1'b1;
        run_scan(8'h01, -1);
        mux_in = 8'hFF;
        run_scan(8'hFF, -1);
        io.io_cont = 1'b0;
        @(negedge clock);
        check("t3_valid_off", 32'(io.io_out_valid), 0);
        check("t3_busy_off", 32'(io.io_busy), 0);

        // Continuous mode dropped mid-scan: word completes, then idle.
        mux_in = 8'h3C;
        io.io_cont = 1'b1;
        run_scan(8'h3C, 3);
        @(negedge clock);
        check("t5_valid_off", 32'(io.io_out_valid), 0);
        check("t5_busy_off", 32'(io.io_busy), 0);
        repeat (10) @(negedge clock);
        check("t5_stay_idle", 32'(io.io_busy), 0);
        check("t5_stay_sel", 32'(io.io_sel), 0);

        // Asynchronous reset in the middle of a scan.
        mux_in = 8'hFF;
        io.io_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            io.io_start = 1'b0;
        end
        check("t4_pre_sel", 32'(io.io_sel), 4);
        #2;
        reset = 1'b1;
        #1;
        check("t4_sel", 32'(io.io_sel), 0);
        check("t4_valid", 32'(io.io_out_valid), 0);
        check("t4_bits", 32'(io.io_out_bits), 0);
        check("t4_busy", 32'(io.io_busy), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("t4_idle", 32'(io.io_busy), 0);
        mux_in = 8'h96;
        io.io_start = 1'b1;
        run_scan(8'h96, -1);
        @(negedge clock);
        check("t4_done", 32'(io.io_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
